// File: rtl/csr_cnt_pkg.sv
// Shared CSR address map, funct3 operation encodings and mcountinhibit bit layout
// for the machine counter array.
package csr_cnt_pkg;

    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_INSTRET       = 12'hC02;
    localparam logic [11:0] CSR_HPMCOUNTER3   = 12'hC03;
    localparam logic [11:0] CSR_HI_OFS        = 12'h080;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    localparam int INH_CY   = 0;
    localparam int INH_IR   = 2;
    localparam int INH_HPM3 = 3;

    // Counter j lives at base+slot and is inhibited by mcountinhibit[slot].
    function automatic int cnt_slot(input int j);
        if (j == 0)      return INH_CY;
        else if (j == 1) return INH_IR;
        else             return INH_HPM3 + j - 2;
    endfunction

    function automatic logic [31:0] inhibit_mask(input int n_hpm);
        logic [31:0] m;
        m = '0;
        m[INH_CY] = 1'b1;
        m[INH_IR] = 1'b1;
        for (int i = 0; i < n_hpm; i++) m[INH_HPM3 + i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] csr_wdata(input csr_op_e op, input logic [31:0] old,
                                              input logic [31:0] opnd);
        case (op)
            CSR_OP_RW: return opnd;
            CSR_OP_RS: return old | opnd;
            CSR_OP_RC: return old & ~opnd;
            default:   return old;
        endcase
    endfunction

endpackage

// File: rtl/csr_cnt_slice.sv
// One free-running counter with independent low/high half writes and a one-cycle
// wrap pulse; a write in the same cycle overrides the increment.
module csr_cnt_slice #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_lo_i,
    input  logic             wr_hi_i,
    input  logic [31:0]      wdata_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [63:0]      merged;

    // Merge in a 64-bit view so a high-half write simply falls off when CNT_W = 32.
    always_comb begin
        merged = 64'(cnt_q);
        if (wr_lo_i) merged[31:0]  = wdata_i;
        if (wr_hi_i) merged[63:32] = wdata_i;
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        if (wr_lo_i || wr_hi_i) begin
            cnt_d = merged[CNT_W-1:0];
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
            ovf_d = &cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/csr_counter_array.sv
// Machine counter CSR block: mcycle, minstret, mhpmcounters, mcountinhibit and
// mhpmevent, with read-only user aliases and a registered one-cycle read port.
module csr_counter_array
    import csr_cnt_pkg::*;
#(
    parameter int NUM_HPM = 4,
    parameter int CNT_W   = 64,
    parameter int NUM_EVT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_csr_ex,
    input  logic [11:0]        csr_ofs_ex,
    input  logic [2:0]         csr_op2_ex,
    input  logic [4:0]         csr_uimm_ex,
    input  logic [31:0]        rs1_sel,
    input  logic               cpu_stat_ex,
    input  logic               retire_ex,
    input  logic [NUM_EVT-1:0] evt_in,
    output logic [31:0]        csr_rd_data,
    output logic               csr_hit,
    output logic               csr_illegal,
    output logic [NUM_HPM+1:0] cntr_ovf
);

    localparam int          NCNT     = NUM_HPM + 2;
    localparam int          NH       = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam logic [31:0] INH_MASK = inhibit_mask(NUM_HPM);

    logic                       accept, do_wr, wr_en;
    csr_op_e                    op;
    logic [31:0]                operand, wdata;
    logic [31:0]                rd_d, rd_q;
    logic                       hit_d, hit_q, ill_d, ill_q, ro_d;
    logic [NCNT-1:0]            sel_lo, sel_hi, wr_lo, wr_hi, inc;
    logic                       sel_inh;
    logic [NH-1:0]              sel_evt;
    logic [31:0]                inh_q, inh_d;
    logic [NH-1:0][4:0]         evt_q, evt_d;
    logic [31:0]                evt_pad;
    logic [NCNT-1:0][CNT_W-1:0] cnt_val;
    logic [NCNT-1:0][63:0]      cnt_ext;

    assign accept  = cpu_stat_ex & cmd_csr_ex;
    assign op      = csr_op_e'(csr_op2_ex[1:0]);
    assign operand = csr_op2_ex[2] ? {27'b0, csr_uimm_ex} : rs1_sel;
    // rs/rc with a zero operand are pure reads and must not steal an increment.
    assign do_wr   = (op == CSR_OP_RW) ||
                     (((op == CSR_OP_RS) || (op == CSR_OP_RC)) && (operand != 32'd0));

    always_comb begin
        rd_d    = '0;
        hit_d   = 1'b0;
        ro_d    = 1'b0;
        sel_lo  = '0;
        sel_hi  = '0;
        sel_inh = 1'b0;
        sel_evt = '0;
        for (int j = 0; j < NCNT; j++) begin
            if (csr_ofs_ex == CSR_MCYCLE + 12'(cnt_slot(j))) begin
                hit_d = 1'b1; sel_lo[j] = 1'b1; rd_d = cnt_ext[j][31:0];
            end
            if (csr_ofs_ex == CSR_MCYCLE + CSR_HI_OFS + 12'(cnt_slot(j))) begin
                hit_d = 1'b1; sel_hi[j] = 1'b1; rd_d = cnt_ext[j][63:32];
            end
            if (csr_ofs_ex == CSR_CYCLE + 12'(cnt_slot(j))) begin
                hit_d = 1'b1; ro_d = 1'b1; rd_d = cnt_ext[j][31:0];
            end
            if (csr_ofs_ex == CSR_CYCLE + CSR_HI_OFS + 12'(cnt_slot(j))) begin
                hit_d = 1'b1; ro_d = 1'b1; rd_d = cnt_ext[j][63:32];
            end
        end
        if (csr_ofs_ex == CSR_MCOUNTINHIBIT) begin
            hit_d = 1'b1; sel_inh = 1'b1; rd_d = inh_q;
        end
        for (int i = 0; i < NUM_HPM; i++) begin
            if (csr_ofs_ex == CSR_MHPMEVENT3 + 12'(i)) begin
                hit_d = 1'b1; sel_evt[i] = 1'b1; rd_d = {27'b0, evt_q[i]};
            end
        end
    end

    assign wdata = csr_wdata(op, rd_d, operand);
    assign wr_en = accept & do_wr & ~ro_d;
    assign ill_d = ro_d & do_wr;
    assign wr_lo = wr_en ? sel_lo : '0;
    assign wr_hi = wr_en ? sel_hi : '0;

    always_comb begin
        inh_d = inh_q;
        evt_d = evt_q;
        if (wr_en && sel_inh) inh_d = wdata & INH_MASK;
        for (int i = 0; i < NUM_HPM; i++) begin
            if (wr_en && sel_evt[i]) evt_d[i] = wdata[4:0];
        end
    end

    // Event k maps to evt_pad[k]; slot 0 and slots past NUM_EVT stay zero.
    always_comb begin
        evt_pad = '0;
        evt_pad[NUM_EVT:1] = evt_in;
        inc = '0;
        inc[0] = ~inh_q[cnt_slot(0)];
        inc[1] = retire_ex & ~inh_q[cnt_slot(1)];
        for (int i = 0; i < NUM_HPM; i++) begin
            inc[2+i] = ~inh_q[cnt_slot(2+i)] & evt_pad[evt_q[i]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            hit_q <= 1'b0;
            ill_q <= 1'b0;
            inh_q <= '0;
            evt_q <= '0;
        end else begin
            if (accept) begin
                rd_q  <= rd_d;
                hit_q <= hit_d;
                ill_q <= ill_d;
            end
            inh_q <= inh_d;
            evt_q <= evt_d;
        end
    end

    for (genvar j = 0; j < NCNT; j++) begin : g_cnt
        csr_cnt_slice #(.CNT_W(CNT_W)) u_slice (
            .clk     (clk),
            .rst     (rst),
            .wr_lo_i (wr_lo[j]),
            .wr_hi_i (wr_hi[j]),
            .wdata_i (wdata),
            .inc_i   (inc[j]),
            .cnt_o   (cnt_val[j]),
            .ovf_o   (cntr_ovf[j])
        );
        assign cnt_ext[j] = 64'(cnt_val[j]);
    end

    assign csr_rd_data = rd_q;
    assign csr_hit     = hit_q;
    assign csr_illegal = ill_q;

endmodule

// File: tb/tb_csr_counter_array.sv
// Directed bench for csr_counter_array: counting, carry/wrap, events, inhibit,
// read-only aliases and asynchronous reset.
module tb_csr_counter_array;

    localparam int NUM_HPM = 4;
    localparam int CNT_W   = 64;
    localparam int NUM_EVT = 8;

    localparam logic [2:0] F_RW  = 3'b001;
    localparam logic [2:0] F_RS  = 3'b010;
    localparam logic [2:0] F_RC  = 3'b011;
    localparam logic [2:0] F_RCI = 3'b111;

    logic               clk;
    logic               rst;
    logic               cmd_csr_ex;
    logic [11:0]        csr_ofs_ex;
    logic [2:0]         csr_op2_ex;
    logic [4:0]         csr_uimm_ex;
    logic [31:0]        rs1_sel;
    logic               cpu_stat_ex;
    logic               retire_ex;
    logic [NUM_EVT-1:0] evt_in;
    logic [31:0]        csr_rd_data;
    logic               csr_hit;
    logic               csr_illegal;
    logic [NUM_HPM+1:0] cntr_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    csr_counter_array #(.NUM_HPM(NUM_HPM), .CNT_W(CNT_W), .NUM_EVT(NUM_EVT)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_csr_ex  (cmd_csr_ex),
        .csr_ofs_ex  (csr_ofs_ex),
        .csr_op2_ex  (csr_op2_ex),
        .csr_uimm_ex (csr_uimm_ex),
        .rs1_sel     (rs1_sel),
        .cpu_stat_ex (cpu_stat_ex),
        .retire_ex   (retire_ex),
        .evt_in      (evt_in),
        .csr_rd_data (csr_rd_data),
        .csr_hit     (csr_hit),
        .csr_illegal (csr_illegal),
        .cntr_ovf    (cntr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge with the result latched.
    task automatic csr_op(input logic [2:0] f3, input logic [11:0] addr,
                          input logic [31:0] rs1, input logic [4:0] uimm);
        cmd_csr_ex  = 1'b1;
        cpu_stat_ex = 1'b1;
        csr_op2_ex  = f3;
        csr_ofs_ex  = addr;
        rs1_sel     = rs1;
        csr_uimm_ex = uimm;
        @(negedge clk);
        cmd_csr_ex  = 1'b0;
        cpu_stat_ex = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cmd_csr_ex = 1'b0; csr_ofs_ex = '0; csr_op2_ex = '0;
        csr_uimm_ex = '0; rs1_sel = '0; cpu_stat_ex = 1'b0; retire_ex = 1'b0; evt_in = '0;
        #1;
        check("reset_rd",  csr_rd_data, 32'h0);
        check("reset_hit", 32'(csr_hit), 32'h0);
        check("reset_ill", 32'(csr_illegal), 32'h0);
        check("reset_ovf", 32'(cntr_ovf), 32'h0);

        // mcycle counts from the first edge after release.
        @(negedge clk); rst = 1'b0;
        repeat (10) @(negedge clk);
        csr_op(F_RS, 12'hB00, 32'h0, 5'd0);
        check("mcycle_10", csr_rd_data, 32'd10);
        check("mcycle_hit", 32'(csr_hit), 32'h1);
        check("mcycle_ill", 32'(csr_illegal), 32'h0);
        csr_op(F_RS, 12'hC00, 32'h0, 5'd0);
        check("cycle_alias", csr_rd_data, 32'd11);
        csr_op(F_RS, 12'hB80, 32'h0, 5'd0);
        check("mcycleh_0", csr_rd_data, 32'h0);

        // Not accepted without cpu_stat_ex: outputs hold.
        cmd_csr_ex = 1'b1; cpu_stat_ex = 1'b0; csr_ofs_ex = 12'h7C0;
        @(negedge clk);
        cmd_csr_ex = 1'b0;
        check("hold_hit", 32'(csr_hit), 32'h1);

        // Carry from bit 31 into bit 32.
        csr_op(F_RW, 12'hB80, 32'h0, 5'd0);
        csr_op(F_RW, 12'hB00, 32'hFFFF_FFFF, 5'd0);
        csr_op(F_RS, 12'hB00, 32'h0, 5'd0);
        check("carry_lo_pre", csr_rd_data, 32'hFFFF_FFFF);
        check("carry_no_ovf", 32'(cntr_ovf), 32'h0);
        csr_op(F_RS, 12'hB80, 32'h0, 5'd0);
        check("carry_hi", csr_rd_data, 32'h1);

        // Full 64-bit wrap.
        csr_op(F_RW, 12'hB80, 32'hFFFF_FFFF, 5'd0);
        csr_op(F_RW, 12'hB00, 32'hFFFF_FFFF, 5'd0);
        check("wrap_ovf_wr", 32'(cntr_ovf), 32'h0);
        @(negedge clk);
        check("wrap_ovf_pulse", 32'(cntr_ovf), 32'h1);
        @(negedge clk);
        check("wrap_ovf_clear", 32'(cntr_ovf), 32'h0);
        csr_op(F_RS, 12'hB80, 32'h0, 5'd0);
        check("wrap_hi", csr_rd_data, 32'h0);
        csr_op(F_RS, 12'hB00, 32'h0, 5'd0);
        check("wrap_lo", csr_rd_data, 32'h2);

        // Event selection for hpm3.
        csr_op(F_RW, 12'h323, 32'd2, 5'd0);
        evt_in = 8'h02;
        repeat (5) @(negedge clk);
        evt_in = 8'h00;
        csr_op(F_RS, 12'hB03, 32'h0, 5'd0);
        check("hpm3_5", csr_rd_data, 32'd5);
        csr_op(F_RW, 12'h323, 32'd9, 5'd0);
        check("evt_pre", csr_rd_data, 32'd2);
        evt_in = 8'hFF;
        repeat (3) @(negedge clk);
        evt_in = 8'h00;
        csr_op(F_RS, 12'hB03, 32'h0, 5'd0);
        check("hpm3_evt9", csr_rd_data, 32'd5);
        csr_op(F_RW, 12'h323, 32'hFFFF_FFE2, 5'd0);
        check("evt_rd9", csr_rd_data, 32'd9);
        csr_op(F_RS, 12'h323, 32'h0, 5'd0);
        check("evt_5bit", csr_rd_data, 32'd2);
        evt_in = 8'h01;
        repeat (2) @(negedge clk);
        evt_in = 8'h02;
        @(negedge clk);
        evt_in = 8'h00;
        csr_op(F_RS, 12'hB03, 32'h0, 5'd0);
        check("hpm3_sel", csr_rd_data, 32'd6);

        // mcountinhibit freezes mcycle and minstret.
        retire_ex = 1'b1;
        csr_op(F_RW, 12'h320, 32'h5, 5'd0);
        csr_op(F_RW, 12'hB00, 32'h100, 5'd0);
        csr_op(F_RW, 12'hB02, 32'h200, 5'd0);
        repeat (3) @(negedge clk);
        csr_op(F_RS, 12'hB00, 32'h0, 5'd0);
        check("inh_mcycle", csr_rd_data, 32'h100);
        csr_op(F_RS, 12'hB02, 32'h0, 5'd0);
        check("inh_minstret", csr_rd_data, 32'h200);
        csr_op(F_RS, 12'h320, 32'h0, 5'd0);
        check("inh_rd", csr_rd_data, 32'h5);
        csr_op(F_RW, 12'h320, 32'hFFFF_FFFF, 5'd0);
        csr_op(F_RS, 12'h320, 32'h0, 5'd0);
        check("inh_mask", csr_rd_data, 32'h7D);
        csr_op(F_RCI, 12'h320, 32'h0, 5'd5);
        csr_op(F_RS, 12'hB00, 32'h0, 5'd0);
        check("resume_mcycle0", csr_rd_data, 32'h100);
        csr_op(F_RS, 12'hB02, 32'h0, 5'd0);
        check("resume_minstret", csr_rd_data, 32'h201);
        retire_ex = 1'b0;
        csr_op(F_RS, 12'hB00, 32'h0, 5'd0);
        check("resume_mcycle1", csr_rd_data, 32'h102);

        // Read-only aliases.
        csr_op(F_RW, 12'hC02, 32'h55, 5'd0);
        check("ro_rw_ill", 32'(csr_illegal), 32'h1);
        check("ro_rw_rd", csr_rd_data, 32'h202);
        csr_op(F_RS, 12'hC02, 32'h0, 5'd0);
        check("ro_rs_ill", 32'(csr_illegal), 32'h0);
        check("ro_minstret", csr_rd_data, 32'h202);
        csr_op(F_RC, 12'hC82, 32'h1, 5'd0);
        check("ro_rc_ill", 32'(csr_illegal), 32'h1);
        csr_op(F_RS, 12'h7C0, 32'h0, 5'd0);
        check("unmapped_hit", 32'(csr_hit), 32'h0);
        check("unmapped_ill", 32'(csr_illegal), 32'h0);
        csr_op(F_RS, 12'hB07, 32'h0, 5'd0);
        check("hpm_oob_hit", 32'(csr_hit), 32'h0);

        // Asynchronous reset mid-count.
        csr_op(F_RW, 12'hB00, 32'h1234, 5'd0);
        csr_op(F_RW, 12'hC00, 32'h1, 5'd0);
        check("pre_rst_rd", csr_rd_data, 32'h1234);
        check("pre_rst_ill", 32'(csr_illegal), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("arst_rd",  csr_rd_data, 32'h0);
        check("arst_hit", 32'(csr_hit), 32'h0);
        check("arst_ill", 32'(csr_illegal), 32'h0);
        check("arst_ovf", 32'(cntr_ovf), 32'h0);
        @(negedge clk); rst = 1'b0;
        csr_op(F_RS, 12'hB00, 32'h0, 5'd0);
        check("post_rst_0", csr_rd_data, 32'h0);
        csr_op(F_RS, 12'hB00, 32'h0, 5'd0);
        check("post_rst_1", csr_rd_data, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_counter_array.md
CSR_COUNTER_ARRAY -- requirements
Module: csr_counter_array

Interface
REQ-001 SHALL have parameter NUM_HPM, default 4, meaning number of mhpmcounter3+ counters (legal 0..29).
REQ-002 SHALL have parameter CNT_W, default 64, meaning implemented counter width (legal 32..64).
REQ-003 SHALL have parameter NUM_EVT, default 8, meaning width of the event input bus (legal 1..31).
REQ-004 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have cmd_csr_ex  input  1  CSR instruction present in EX.
REQ-007 SHALL have csr_ofs_ex  input  12  CSR address.
REQ-008 SHALL have csr_op2_ex  input  3  funct3: bit2 = immediate; 01 = rw, 10 = rs, 11 = rc.
REQ-009 SHALL have csr_uimm_ex  input  5  immediate operand.
REQ-010 SHALL have rs1_sel  input  32  register operand.
REQ-011 SHALL have cpu_stat_ex  input  1  EX stage valid/executing qualifier.
REQ-012 SHALL have retire_ex  input  1  one instruction retired this cycle.
REQ-013 SHALL have evt_in  input  NUM_EVT  per-cycle event strobes.
REQ-014 SHALL have csr_rd_data  output  32  registered read data.
REQ-015 SHALL have csr_hit  output  1  registered; address belongs to this block.
REQ-016 SHALL have csr_illegal  output  1  registered; write attempted to a read-only alias.
REQ-017 SHALL have cntr_ovf  output  NUM_HPM+2  one-cycle wrap pulses: [0] mcycle, [1] minstret, [2+i] hpm i.

Function
REQ-018 SHALL decode mcycle 0xB00/0xB80, minstret 0xB02/0xB82, mhpmcounter(3+i) 0xB03+i/0xB83+i, mcountinhibit 0x320, mhpmevent(3+i) 0x323+i, and read-only aliases 0xC00, 0xC02, 0xC03+i (plus high halves at +0x80); all other addresses give csr_hit = 0 and read 0.
REQ-019 SHALL accept an access only when cpu_stat_ex & cmd_csr_ex, and SHALL latch csr_rd_data, csr_hit and csr_illegal on that edge (1-cycle latency), holding them otherwise.
REQ-020 SHALL return the pre-write value of the CSR on csr_rd_data.
REQ-021 SHALL form write data as: rw = operand; rs = old | operand; rc = old & ~operand; operand = immediate ? zero-extended uimm : rs1_sel.
REQ-022 SHALL write only on accepted rw/rs/rc accesses to 0xBxx/0x3xx addresses; accesses to 0xCxx with rw, or with rs/rc and a nonzero operand, SHALL set csr_illegal and modify nothing.
REQ-023 SHALL increment mcycle every cycle, minstret when retire_ex = 1, and hpm i when mhpmevent(i) = k with 1 <= k <= NUM_EVT and evt_in[k-1] = 1; event values 0 or > NUM_EVT count nothing.
REQ-024 SHALL suppress incrementing for counter j while mcountinhibit bit j is set (bit 0 = mcycle, bit 2 = minstret, bit 3+i = hpm i; bit 1 and unimplemented bits read 0).
REQ-025 SHALL give a CSR write priority over an increment to the same counter in the same cycle; the written value is stored unincremented.
REQ-026 SHALL write the low half into bits [31:0] and the high half into bits [CNT_W-1:32] only, leaving the other half unchanged.
REQ-027 SHALL carry from bit 31 to bit 32 within one cycle (no stale high half).
REQ-028 SHALL zero-extend reads of bits above CNT_W-1, and SHALL read high halves as 0 when CNT_W = 32.
REQ-029 SHALL pulse cntr_ovf[j] for exactly one cycle when counter j increments from all-ones to zero; it SHALL NOT pulse when the same cycle contains a write.
REQ-030 SHALL store mhpmevent as 5 bits, reading the upper bits as 0.

Reset
REQ-031 SHALL clear all counters, mcountinhibit, mhpmevent registers, csr_rd_data, csr_hit, csr_illegal and cntr_ovf to 0 immediately when rst is asserted, independent of clk.
REQ-032 SHALL, after rst deasserts, begin counting mcycle on the first rising edge of clk.

Structure
REQ-033 SHALL place the CSR address constants, op2 encodings and the inhibit-bit indices in the shared package csr_cnt_pkg.
REQ-034 SHALL implement each counter as sub-module csr_cnt_slice (write-low, write-high, increment enable, overflow pulse), instantiated NUM_HPM+2 times.

Verification
REQ-035 SHALL check: rst released -> after 10 cycles, csrrs x0 on 0xB00 reads 10 (+/- fixed pipeline offset), then 0xC00 reads the same value minus nothing written.
REQ-036 SHALL check: csrrw 0xB00 = 0xFFFFFFFF, high = 0 -> next cycle low = 0, high = 1, no ovf; with CNT_W = 64 and all-ones -> wrap to 0 with cntr_ovf[0] pulsed for one cycle.
REQ-037 SHALL check: mhpmevent3 = 2, evt_in[1] held for 5 cycles -> mhpmcounter3 = 5; mhpmevent3 = 9 with NUM_EVT = 8 -> counter does not change.
REQ-038 SHALL check: mcountinhibit = 0x5 -> mcycle and minstret frozen while retire_ex = 1; clearing it -> both resume.
REQ-039 SHALL check: csrrw to 0xC02 -> csr_illegal = 1, minstret unchanged; csrrs 0xC02 with x0 -> csr_illegal = 0.
REQ-040 SHALL check: rst asserted mid-count with counter = 0x1234 -> all outputs 0 before the next clk edge.
